// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM port arbiter.
// Optional build macro: ARB_ROUND_ROBIN_EN (alternating arbitration FSM).
package bram_arb_pkg;

    // Default BRAM word-address width (depth = 2^ADDR_W words)
    localparam int unsigned ADDR_W_DEFAULT = 16;

    // Word indices that benches poll for completion and result
    localparam int unsigned DONE_WORD_IDX   = 1025;
    localparam int unsigned RESULT_WORD_IDX = 1024;

    // Owner of the response returning from the BRAM this cycle
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_sel_e;

    // Which requester wins when both are valid
    typedef enum logic {
        PRIO_D  = 1'b0,
        PRIO_IF = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bram_arb_pick.sv
// Combinational 2-way grant between fetch and data requests.
module bram_arb_pick (
    input  logic en,
    input  logic if_valid,
    input  logic d_valid,
    input  logic prio_if,
    output logic gnt_if_c,
    output logic gnt_d_c
);

    // Data wins unless fetch is also valid and currently favoured
    always_comb begin
        gnt_if_c = 1'b0;
        gnt_d_c  = 1'b0;
        if (en) begin
            if (d_valid && (!if_valid || !prio_if)) begin
                gnt_d_c = 1'b1;
            end else if (if_valid) begin
                gnt_if_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port, 1-cycle-latency BRAM between fetch and load/store.
// ARB_ROUND_ROBIN_EN defined: alternating PRIO_D/PRIO_IF arbitration FSM.
// Undefined: fixed priority, data always wins a conflict.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_addr,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [31:0]       d_addr,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [31:0]       d_wdata,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic      gnt_if;
    logic      gnt_d;
    logic      prio_if;
    resp_sel_e resp_sel_q;
    resp_sel_e resp_sel_d;

    // Byte-offset and above-depth address bits are dropped by the wrap
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr, d_addr};

`ifdef ARB_ROUND_ROBIN_EN
    arb_state_e state_q;
    arb_state_e state_d;

    // Arbitration state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PRIO_D;
        end else begin
            state_q <= state_d;
        end
    end

    // After any grant favour the requester that was not served; hold otherwise
    always_comb begin
        state_d = state_q;
        if (gnt_d) begin
            state_d = PRIO_IF;
        end else if (gnt_if) begin
            state_d = PRIO_D;
        end
    end

    assign prio_if = (state_q == PRIO_IF);
`else
    assign prio_if = 1'b0;
`endif

    // Grant is suppressed while reset is asserted
    bram_arb_pick u_pick (
        .en       (rst_n),
        .if_valid (if_valid),
        .d_valid  (d_valid),
        .prio_if  (prio_if),
        .gnt_if_c (gnt_if),
        .gnt_d_c  (gnt_d)
    );

    assign if_ready = gnt_if;
    assign d_ready  = gnt_d;

    // Drive the BRAM from the granted requester, idle otherwise
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (gnt_d) begin
            mem_en    = 1'b1;
            mem_we    = d_we ? d_wstrb : 4'h0;
            mem_addr  = d_addr[ADDR_W+1:2];
            mem_wdata = d_wdata;
        end else if (gnt_if) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr[ADDR_W+1:2];
        end
    end

    // Response owner register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_sel_q <= RESP_NONE;
        end else begin
            resp_sel_q <= resp_sel_d;
        end
    end

    // Owner of next cycle's response is whoever is granted now
    always_comb begin
        resp_sel_d = RESP_NONE;
        if (gnt_d) begin
            resp_sel_d = RESP_D;
        end else if (gnt_if) begin
            resp_sel_d = RESP_IF;
        end
    end

    assign if_rvalid = (resp_sel_q == RESP_IF);
    assign d_rvalid  = (resp_sel_q == RESP_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares the single-port, 1-cycle-latency program/data BRAM between the core's instruction-fetch port and its load/store port. It sits between the multi-cycle core and `bram_mem` inside `top`. Each cycle it grants at most one request, drives the BRAM, and returns the read data or write acknowledge to the owning requester one cycle later. Address wrap to the BRAM depth is done here (e.g. byte 0x80001004 → word 1025 with ADDR_W=16).

## Interface
- `ADDR_W`, 16, BRAM word-address width (depth = 2^ADDR_W words)
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_valid`  in  1  fetch request
- `if_ready`  out  1  fetch request granted this cycle
- `if_addr`  in  32  fetch byte address
- `if_rvalid`  out  1  fetch read data valid
- `if_rdata`  out  32  fetch read data
- `d_valid`  in  1  load/store request
- `d_ready`  out  1  load/store request granted this cycle
- `d_addr`  in  32  load/store byte address
- `d_we`  in  1  1 = store
- `d_wstrb`  in  4  store byte enables, bit i = byte i (little-endian)
- `d_wdata`  in  32  store data
- `d_rvalid`  out  1  load data valid, or store acknowledge
- `d_rdata`  out  32  load data
- `mem_en`  out  1  BRAM enable
- `mem_we`  out  4  BRAM byte write enables
- `mem_addr`  out  ADDR_W  BRAM word index = `addr[ADDR_W+1:2]`
- `mem_wdata`  out  32  BRAM write data
- `mem_rdata`  in  32  BRAM read data, valid the cycle after `mem_en`

## Operation
- Handshake: a requester holds valid/addr/we/wstrb/wdata stable until it sees ready. A transfer occurs when valid && ready. Ready is combinational from the valids and the arbitration state.
- At most one grant per cycle. With no valid, `mem_en`=0 and `mem_we`=0.
- Grant source drives `mem_addr`/`mem_en`. For a data store: `mem_we = d_wstrb`. Loads and fetches: `mem_we`=0. Address bits [1:0] and bits above ADDR_W+1 are ignored (wrap).
- Owner register `resp_sel` (NONE/IF/D) is loaded at grant.
- Next cycle, the owner's rvalid pulses for exactly 1 cycle. `if_rdata`/`d_rdata` pass `mem_rdata` through unregistered. Stores also pulse `d_rvalid`, with rdata undefined.
- The pipeline accepts a new grant every cycle, including the cycle in which the previous response returns. Back-to-back throughput is 1 request/cycle.
- Arbitration FSM states: PRIO_D (data wins a conflict) and PRIO_IF (fetch wins a conflict).
  - On a conflicting cycle the winner is granted. The state then flips to favour the loser.
  - On a non-conflicting grant, the state is set to favour the requester not just served.
  - With no grant, the state holds.

## Timing
- Reset values: `if_ready`=`d_ready`=0 during reset. Also during reset: `if_rvalid`=`d_rvalid`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `resp_sel`=NONE, FSM=PRIO_D.
- Latency: grant in cycle N → rvalid in cycle N+1. No combinational path from `mem_rdata` to any ready.
- Simultaneous valid: exactly one ready high. The loser keeps valid and is served no later than the next cycle.
- Reset asserted mid-transfer: the in-flight response is discarded and no rvalid is issued after reset release. The first request after release is granted in its first valid cycle.
- A store followed by a load to the same word, granted in consecutive cycles, returns the new data (BRAM write-first is relied upon; the arbiter adds no forwarding).

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: the alternating PRIO_D/PRIO_IF FSM described above.
- Not defined: fixed priority, data always wins a conflict, and the FSM is not built. Fetch can starve while `d_valid` stays high. This is acceptable for the multi-cycle core, which never issues both continuously.

## Structure
- Shared package `bram_arb_pkg` holds:
  - `resp_sel_e` (NONE/IF/D)
  - `arb_state_e` (PRIO_D/PRIO_IF)
  - the default `ADDR_W` constant
  - the done/result word indices (1025/1024) used by benches
- One sub-module is natural: `bram_arb_pick`, a combinational 2-way grant from valids plus priority state. Registering stays in the top arbiter.

## Test plan
- Fetch only: `if_addr`=0x0, 4, 8 on consecutive cycles with mem[0..2] preloaded → `if_ready` high each cycle. `if_rvalid` high cycles 1–3 with mem[0], mem[1], mem[2].
- Store with wrap: `d_addr`=0x80001004, `d_wstrb`=0xF, `d_wdata`=0xDEADBEEF → mem[1025]=0xDEADBEEF, and `d_rvalid` pulses one cycle later.
- Byte store: mem[1024]=0x11223344, `d_wstrb`=0x2, wdata=0x0000AA00 → mem[1024]=0x1122AA44.
- Conflict, round-robin build: both valid for 4 cycles → grants alternate D, IF, D, IF. Fixed-priority build → D on all 4 cycles, and `if_ready`=0 throughout.
- Reset mid-read: grant a fetch, then assert `rst_n`=0 in the next cycle → `if_rvalid` stays 0 through and after reset. A new fetch after release is granted immediately.
- Store then load to word 1024 on back-to-back grants → the load returns the stored value.
